// File: rtl/fm_pkg.sv
// Shared types and helpers for the FM receive path.
package fm_pkg;

  typedef enum logic {
    IQ_I = 1'b0,
    IQ_Q = 1'b1
  } iq_e;

  localparam int IQ_NUM = int'(IQ_Q) + 1;

  // Accumulator width needed by a CIC so that integrator wrap cancels in the combs.
  function automatic int cic_acc_w(input int n, input int r_log2, input int order);
    return n + order * r_log2;
  endfunction

endpackage

// File: rtl/fm_cic_chain.sv
// One CIC channel: ORDER pipelined integrators feeding ORDER combs evaluated on dump.
module fm_cic_chain
  import fm_pkg::*;
#(
  parameter int N     = 12,
  parameter int ORDER = 3,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic signed [N-1:0]     din,
  input  logic [ORDER-1:0]        int_en,
  input  logic                    dump,
  output logic signed [ACC_W-1:0] result
);

  logic signed [ACC_W-1:0] integ    [ORDER];
  logic signed [ACC_W-1:0] comb_dly [ORDER];
  logic signed [ACC_W-1:0] comb_in  [ORDER];
  logic signed [ACC_W-1:0] din_ext;

  assign din_ext = {{(ACC_W - N){din[N-1]}}, din};

  // Integrators wrap modulo 2^ACC_W; the comb differences undo the wrap.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
    end else begin
      if (int_en[0]) integ[0] <= integ[0] + din_ext;
      for (int k = 1; k < ORDER; k++) begin
        if (int_en[k]) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    acc = integ[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = acc;
      acc        = acc - comb_dly[k];
    end
    result = acc;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int k = 0; k < ORDER; k++) comb_dly[k] <= '0;
    end else if (dump) begin
      for (int k = 0; k < ORDER; k++) comb_dly[k] <= comb_in[k];
    end
  end

endmodule

// File: rtl/fm_cic_decimator.sv
// I/Q CIC decimator between the FM mixer and discriminator, with a one-entry
// valid/ready output register and a sticky overrun flag.
module fm_cic_decimator
  import fm_pkg::*;
#(
  parameter int N      = 12,
  parameter int R_LOG2 = 4,
  parameter int ORDER  = 3,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic signed [N-1:0]     in [2],
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out [2],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int                ACC_W      = cic_acc_w(N, R_LOG2, ORDER);
  localparam int                SHIFT      = ACC_W - OUT_W;
  localparam logic [R_LOG2-1:0] PHASE_LAST = '1;

  logic [ORDER-1:0]        vld_pipe;
  logic [ORDER-1:0]        int_en;
  logic [R_LOG2-1:0]       phase;
  logic                    tick;
  logic                    dump;
  logic                    load_ovr;
  logic signed [ACC_W-1:0] acc_res [IQ_NUM];

  // Stage k integrates when the sample has reached it, so gaps never skew stages.
  assign int_en   = (vld_pipe << 1) | ORDER'(in_valid);
  assign tick     = vld_pipe[ORDER-1];
  assign dump     = tick && (phase == PHASE_LAST);
  assign load_ovr = dump && out_valid && !out_ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vld_pipe <= '0;
      phase    <= '0;
    end else begin
      vld_pipe <= int_en;
      if (tick) phase <= phase + R_LOG2'(1);
    end
  end

  for (genvar ch = 0; ch < IQ_NUM; ch++) begin : g_chain
    fm_cic_chain #(
      .N     (N),
      .ORDER (ORDER),
      .ACC_W (ACC_W)
    ) u_chain (
      .clk     (clk),
      .n_reset (n_reset),
      .din     (in[ch]),
      .int_en  (int_en),
      .dump    (dump),
      .result  (acc_res[ch])
    );
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int ch = 0; ch < IQ_NUM; ch++) out[ch] <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (dump) begin
        for (int ch = 0; ch < IQ_NUM; ch++) out[ch] <= OUT_W'(acc_res[ch] >>> SHIFT);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Setting wins over a simultaneous clear.
      if (load_ovr)         overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule
